usart_sync_rx: RTL
==================

Name: usart_sync_rx

Overview:
- Synchronous serial receiver for the link from the Chameleon USB microcontroller to the FPGA: data on usart_tx, bit clock on usart_clk, flow control back on an RTS-style line.
- Complements the existing FPGA-to-USB transmit path used for reconfiguration; carries host commands and data into the sysclk domain.
- Synchronises the pins, deframes 8N1 bytes clocked by serial_clk rising edges, and buffers them in a FIFO.
- Presents bytes to cfide through a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 8, number of byte entries; power of 2, minimum 4.
- SYNC_STAGES, 2, synchroniser flops on serial_clk and serial_rxd; minimum 2.
- TIMEOUT, 4095, sysclk cycles without a serial_clk rising edge before a partial frame is aborted.

Ports:
- sysclk  in  1  system clock; all logic is in this domain.
- n_reset  in  1  asynchronous active-low reset.
- serial_clk  in  1  bit clock from the USB microcontroller (usart_clk); asynchronous.
- serial_rxd  in  1  serial data (usart_tx); idles high; asynchronous.
- serial_rts_n  out  1  low = FIFO can accept data; high = sender must pause.
- rx_data  out  8  byte at the FIFO head.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts rx_data.
- frame_err  out  1  one-cycle pulse on a bad stop bit or a timeout abort.
- overrun  out  1  sticky; set when a byte is dropped because the FIFO is full.
- clr_overrun  in  1  clears overrun.
- fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset values: rx_data 0, rx_valid 0, serial_rts_n 1, frame_err 0, overrun 0, fifo_level 0, FSM IDLE. Reset is legal at any time, including mid-frame: the partial byte and all FIFO contents are discarded.
- Synchronisers: serial_clk and serial_rxd each pass through SYNC_STAGES flops.
  - Edge strobe = synced clk is 1 and its previous value was 0.
  - On each edge strobe, the synced rxd is the sampled bit.
- FSM:
  - IDLE: on an edge with bit=0 (start bit), clear the bit counter and go to DATA. An edge with bit=1 stays in IDLE.
  - DATA: on each edge, shift the bit in LSB first; bitcnt 0..7. After the 8th bit go to STOP.
  - STOP, bit=1: push the shift register and go to IDLE.
  - STOP, bit=0: frame_err pulse, byte discarded, go to WAIT_IDLE.
  - WAIT_IDLE: stay until an edge samples bit=1, then go to IDLE. This prevents resync on a stuck-low line.
- Timeout: a counter runs in DATA and STOP, reset on every edge strobe. When it reaches TIMEOUT: frame_err pulse, partial byte dropped, go to IDLE. The counter saturates and does not wrap.
- FIFO: circular buffer with read/write pointers wrapping modulo FIFO_DEPTH.
  - Push when FIFO not full.
  - Push when full and no pop in the same cycle: byte dropped, overrun set.
  - Push and pop in the same cycle while full: both occur, level unchanged, no overrun.
  - Pop when rx_valid && rx_ready. rx_ready while empty has no effect.
  - rx_data is valid whenever rx_valid=1 and is stable until popped.
- Latency: the stop-bit edge strobe registers the push; rx_valid=1 in the next sysclk cycle. From the serial_clk pin rising edge, that is SYNC_STAGES+2 sysclk cycles.
- Flow control: serial_rts_n = 1 when fifo_level >= FIFO_DEPTH-1, otherwise 0. It is registered and reflects the level with one cycle delay. The one free slot of margin absorbs a byte already in flight.
- overrun: cleared by clr_overrun. If set and clear occur in the same cycle, set wins.
- frame_err and overrun never block reception; the next start bit is accepted normally.
- Minimum supported serial_clk: high and low phases each >= SYNC_STAGES+1 sysclk cycles.

Test Plan:
- Idle line, send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1 LSB first, stop 1) with rx_ready=1 -> rx_valid for exactly 1 cycle with rx_data=0xA5; fifo_level returns to 0; frame_err=0.
- Send 0x01..0x09 with rx_ready=0, FIFO_DEPTH=8 -> serial_rts_n=1 once level reaches 7; level=8 after 0x08; 0x09 dropped, overrun=1. Pop all -> read 0x01..0x08 in order; clr_overrun -> overrun=0.
- Send 0x3C with stop bit 0 -> frame_err pulses once, level unchanged. Hold rxd=0 for 3 more edges: no new frame. Then rxd=1 edge, then send 0x55 -> rx_data=0x55.
- Send start plus 4 data bits, then stop serial_clk for TIMEOUT+10 cycles -> frame_err pulse at TIMEOUT, FSM in IDLE; next full byte 0xC3 received correctly.
- FIFO full (8 entries) with rx_ready=1 on the same cycle as a new stop-bit push -> level stays 8, overrun=0, head advances, new byte stored last.
- Assert n_reset low mid-DATA with 3 bytes queued -> rx_valid=0, fifo_level=0, serial_rts_n=1 during reset. After release, serial_rts_n=0 and the next byte 0x7E is received cleanly.

Source files
------------

// File: rtl/usart_sync_rx.sv
// Synchronous 8N1 receiver: pins are synchronised into sysclk, bytes are deframed on
// serial_clk rising edges, queued in a FIFO and drained through a valid/ready port.
module usart_sync_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4095
) (
  input  logic                          sysclk,
  input  logic                          n_reset,
  input  logic                          serial_clk,
  input  logic                          serial_rxd,
  output logic                          serial_rts_n,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DATA      = 2'd1,
    S_STOP      = 2'd2,
    S_WAIT_IDLE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_rxd_sync;
  logic                   r_clk_prev;
  logic                   w_edge;
  logic                   w_bit;

  state_t                 r_state, w_state_nxt;
  logic [7:0]             r_shift, w_shift_nxt;
  logic [2:0]             r_bitcnt, w_bitcnt_nxt;
  logic [TW-1:0]          r_tmo, w_tmo_nxt;
  logic                   w_push_nxt;
  logic                   w_ferr_nxt;
  logic                   r_push;
  logic [7:0]             r_push_data;
  logic                   r_frame_err;

  logic [7:0]             r_mem [FIFO_DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [LW-1:0]          r_level;
  logic                   r_overrun;
  logic                   r_rts_n;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_wr;

  // rxd synchroniser resets to the idle-high level so reset never fakes a start bit.
  always_ff @(posedge sysclk or negedge n_reset) begin
    if (!n_reset) begin
      r_clk_sync <= '0;
      r_rxd_sync <= '1;
      r_clk_prev <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], serial_clk};
      r_rxd_sync <= {r_rxd_sync[SYNC_STAGES-2:0], serial_rxd};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
  assign w_bit  = r_rxd_sync[SYNC_STAGES-1];

  always_ff @(posedge sysclk or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_tmo       <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_tmo       <= w_tmo_nxt;
      r_push      <= w_push_nxt;
      r_frame_err <= w_ferr_nxt;
      if (w_push_nxt) r_push_data <= r_shift;
    end
  end

  // The timeout counter only advances inside a frame and stops at TIMEOUT.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_tmo_nxt    = '0;
    w_push_nxt   = 1'b0;
    w_ferr_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_edge && !w_bit) begin
          w_bitcnt_nxt = '0;
          w_state_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        if (w_edge) begin
          w_shift_nxt  = {w_bit, r_shift[7:1]};
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) w_state_nxt = S_STOP;
        end else if (r_tmo == TW'(TIMEOUT)) begin
          w_ferr_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      S_STOP: begin
        if (w_edge) begin
          if (w_bit) begin
            w_push_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_WAIT_IDLE;
          end
        end else if (r_tmo == TW'(TIMEOUT)) begin
          w_ferr_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (w_edge && w_bit) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A push into a full FIFO still lands if the head is popped in the same cycle.
  assign w_full = (r_level == LW'(FIFO_DEPTH));
  assign w_pop  = rx_valid && rx_ready;
  assign w_wr   = r_push && (!w_full || w_pop);

  always_ff @(posedge sysclk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_push_data;
  end

  always_ff @(posedge sysclk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
      r_rts_n   <= 1'b1;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (r_push && w_full && !w_pop) r_overrun <= 1'b1;
      else if (clr_overrun)           r_overrun <= 1'b0;
      r_rts_n <= (r_level >= LW'(FIFO_DEPTH - 1));
    end
  end

  assign rx_valid     = (r_level != '0);
  assign rx_data      = rx_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign fifo_level   = r_level;
  assign overrun      = r_overrun;
  assign serial_rts_n = r_rts_n;
  assign frame_err    = r_frame_err;
  assign dbg_state    = r_state;

endmodule
